// File: rtl/spi_sprite_loader.sv
// SPI command receiver in the vgaclk domain: frames 32-bit words that load sprite palettes,
// packed pixels, text streams and health values, and serves sprite/text lookups to the renderer.
//
//   state       | meaning
//   GET_CMD     | waiting for a command word
//   GET_PALETTE | receiving 2^BITSPERPIXEL palette words for sprite sel
//   GET_DATA    | receiving packed pixel words, unpacking one pixel per clock
//   GET_TEXT    | receiving STREAMLEN/4 words of 4 characters each
//   DISCARD     | bad command seen; ignore words until cs_n rises
module spi_sprite_loader #(
  parameter int NUMSPRITES       = 8,
  parameter int SPRITEWIDTH      = 64,
  parameter int SPRITEHEIGHT     = 64,
  parameter int BITSPERPIXEL     = 4,
  parameter int NUMSTREAMS       = 8,
  parameter int STREAMLEN        = 12,
  parameter int TRANSPARENTINDEX = 0
) (
  input  logic                              vgaclk,
  input  logic                              reset,
  input  logic                              sck,
  input  logic                              mosi,
  input  logic                              cs_n,
  input  logic [$clog2(NUMSPRITES+1)-1:0]   spriteToDraw,
  input  logic [9:0]                        spriteX,
  input  logic [9:0]                        spriteY,
  output logic [7:0]                        spriteR,
  output logic [7:0]                        spriteG,
  output logic [7:0]                        spriteB,
  output logic                              spriteValid,
  input  logic [$clog2(NUMSTREAMS)-1:0]     streamToDraw,
  input  logic [$clog2(STREAMLEN)-1:0]      charIndex,
  output logic [7:0]                        ch,
  output logic [6:0]                        health1,
  output logic [6:0]                        health2,
  output logic                              busy,
  output logic                              error,
  output logic [7:0]                        leds
);

  localparam int PIX   = SPRITEWIDTH * SPRITEHEIGHT;
  localparam int DEPTH = NUMSPRITES * PIX;
  localparam int AW    = $clog2(DEPTH);
  localparam int PCW   = $clog2(PIX);
  localparam int NPAL  = 1 << BITSPERPIXEL;
  localparam int PPW   = 32 / BITSPERPIXEL;
  localparam int SIW   = $clog2(NUMSPRITES);
  localparam int STW   = $clog2(NUMSTREAMS);
  localparam int CIW   = $clog2(STREAMLEN);

  typedef enum logic [2:0] {
    GET_CMD     = 3'd0,
    GET_PALETTE = 3'd1,
    GET_DATA    = 3'd2,
    GET_TEXT    = 3'd3,
    DISCARD     = 3'd4
  } state_t;

  logic [1:0]  sck_ff, mosi_ff, cs_ff;
  logic        sck_d, cs_s, word_strobe;
  logic [4:0]  bit_cnt;
  logic [30:0] shift;
  logic [31:0] q;

  state_t                    state;
  logic [2:0]                last_cmd;
  logic [3:0]                sel;
  logic                      load_px;
  logic [BITSPERPIXEL-1:0]   pal_cnt;
  logic [PCW-1:0]            pix_cnt;
  logic [CIW-1:0]            text_cnt;
  logic [5:0]                unpack_cnt;
  logic [31:0]               unpack_buf;

  logic [BITSPERPIXEL-1:0]   pix_ram [DEPTH];
  logic [23:0]               palette [NUMSPRITES][NPAL];
  logic [7:0]                streams [NUMSTREAMS][STREAMLEN];

  logic                      pix_we, pal_we;
  logic [AW-1:0]             pix_waddr, rd_addr;
  logic [BITSPERPIXEL-1:0]   pix_wdata, rd_idx;
  logic                      look_q;
  logic [SIW-1:0]            spr_q;

  assign cs_s = cs_ff[1];
  assign leds = {state, 2'b00, last_cmd};

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      sck_ff      <= '0;
      mosi_ff     <= '0;
      cs_ff       <= 2'b11;
      sck_d       <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      q           <= '0;
      word_strobe <= 1'b0;
    end else begin
      sck_ff      <= {sck_ff[0], sck};
      mosi_ff     <= {mosi_ff[0], mosi};
      cs_ff       <= {cs_ff[0], cs_n};
      sck_d       <= sck_ff[1];
      word_strobe <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_ff[1] && !sck_d) begin
        shift   <= {shift[29:0], mosi_ff[1]};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 5'd31) begin
          q           <= {shift, mosi_ff[1]};
          word_strobe <= 1'b1;
        end
      end
    end
  end

  // Unpacking runs to completion on its own, so a frame ending right after the last word still lands every pixel.
  assign pix_we    = (unpack_cnt != '0);
  assign pix_waddr = AW'(int'(sel) * PIX + int'(pix_cnt));
  assign pix_wdata = unpack_buf[31 -: BITSPERPIXEL];
  assign pal_we    = (state == GET_PALETTE) && word_strobe && !cs_s;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state      <= GET_CMD;
      busy       <= 1'b0;
      error      <= 1'b0;
      health1    <= '0;
      health2    <= '0;
      last_cmd   <= '0;
      sel        <= '0;
      load_px    <= 1'b0;
      pal_cnt    <= '0;
      pix_cnt    <= '0;
      text_cnt   <= '0;
      unpack_cnt <= '0;
      unpack_buf <= '0;
      for (int s = 0; s < NUMSTREAMS; s++)
        for (int c = 0; c < STREAMLEN; c++)
          streams[s][c] <= 8'h20;
    end else begin
      if (pix_we) begin
        unpack_buf <= unpack_buf << BITSPERPIXEL;
        unpack_cnt <= unpack_cnt - 1'b1;
        pix_cnt    <= pix_cnt + 1'b1;
        if (state == GET_DATA && pix_cnt == PCW'(PIX - 1)) begin
          state <= GET_CMD;
          busy  <= 1'b0;
        end
      end
      if (cs_s) begin
        state <= GET_CMD;
        busy  <= 1'b0;
      end else if (word_strobe) begin
        case (state)
          GET_CMD: begin
            last_cmd <= q[10:8];
            case (q[10:8])
              3'd0, 3'd3: begin
                if (int'(q[3:0]) >= NUMSPRITES) begin
                  error <= 1'b1;
                  state <= DISCARD;
                end else begin
                  sel     <= q[3:0];
                  load_px <= (q[10:8] == 3'd0);
                  pal_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= GET_PALETTE;
                end
              end
              3'd1: begin
                if (int'(q[3:0]) >= NUMSTREAMS) begin
                  error <= 1'b1;
                  state <= DISCARD;
                end else begin
                  sel      <= q[3:0];
                  text_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= GET_TEXT;
                end
              end
              3'd2: begin
                health1 <= q[30:24];
                health2 <= q[22:16];
              end
              default: begin
                error <= 1'b1;
                state <= DISCARD;
              end
            endcase
          end
          GET_PALETTE: begin
            pal_cnt <= pal_cnt + 1'b1;
            if (pal_cnt == {BITSPERPIXEL{1'b1}}) begin
              if (load_px) begin
                pix_cnt <= '0;
                state   <= GET_DATA;
              end else begin
                busy  <= 1'b0;
                state <= GET_CMD;
              end
            end
          end
          GET_DATA: begin
            unpack_buf <= q;
            unpack_cnt <= 6'(PPW);
          end
          GET_TEXT: begin
            for (int j = 0; j < 4; j++)
              streams[sel[STW-1:0]][CIW'(4 * int'(text_cnt) + j)] <= q[31 - 8*j -: 8];
            text_cnt <= text_cnt + 1'b1;
            if (text_cnt == CIW'(STREAMLEN / 4 - 1)) begin
              busy  <= 1'b0;
              state <= GET_CMD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read-before-write: a same-cycle write to the looked-up pixel returns the old index.
  assign rd_addr = AW'((int'(spriteToDraw) - 1) * PIX + int'(spriteY) * SPRITEWIDTH + int'(spriteX));

  always_ff @(posedge vgaclk) begin
    if (pix_we) pix_ram[pix_waddr] <= pix_wdata;
    if (pal_we) palette[sel[SIW-1:0]][pal_cnt] <= q[23:0];
    rd_idx <= pix_ram[rd_addr];
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      look_q      <= 1'b0;
      spr_q       <= '0;
      spriteR     <= '0;
      spriteG     <= '0;
      spriteB     <= '0;
      spriteValid <= 1'b0;
      ch          <= '0;
    end else begin
      look_q <= (spriteToDraw != '0) && (int'(spriteX) < SPRITEWIDTH) && (int'(spriteY) < SPRITEHEIGHT);
      spr_q  <= SIW'(spriteToDraw - 1'b1);
      if (look_q && rd_idx != BITSPERPIXEL'(TRANSPARENTINDEX)) begin
        {spriteR, spriteG, spriteB} <= palette[spr_q][rd_idx];
        spriteValid                 <= 1'b1;
      end else begin
        {spriteR, spriteG, spriteB} <= '0;
        spriteValid                 <= 1'b0;
      end
      if (int'(charIndex) < STREAMLEN) ch <= streams[streamToDraw][charIndex];
      else                             ch <= 8'h20;
    end
  end

endmodule
